// File: rtl/fixed_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_encoder_if
//  Description : Operand/result handshake bundle for fixed_encoder.
//                Input side : in_valid/in_ready/fixed_in (Q16.16 operand)
//                Output side: out_valid/out_ready/fp_out/inexact (IEEE single)
//                master = producer/consumer environment, slave = encoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface fixed_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fixed_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_out;
    logic        inexact;

    modport master (
        output in_valid,
        input  in_ready,
        output fixed_in,
        input  out_valid,
        output out_ready,
        input  fp_out,
        input  inexact
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  fixed_in,
        output out_valid,
        input  out_ready,
        output fp_out,
        output inexact
    );
endinterface
`default_nettype wire

// File: rtl/fixed_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_encoder
//  Description : Converts a signed Q16.16 operand into an IEEE-754 single
//                precision value, round-to-nearest-even. One operand in
//                flight; normalisation shifts one bit per cycle.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - fixed_encoder_if.slave (operand in, result out)
//  Revision    : 1.0  initial release
// ============================================================================
module fixed_encoder (
    input  wire logic       clk,
    input  wire logic       rst,
    fixed_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Exponent of a value whose leading one sits at mag[31] with no shift:
    // 2^15 -> biased 127 + 15.
    localparam logic [7:0] c_EXP_TOP = 8'd142;

    state_t      r_state;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [4:0]  r_count;
    logic [31:0] r_fp;
    logic        r_inexact;
    logic        r_out_valid;

    logic [31:0] w_abs;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [30:0] w_rounded;

    // 0x80000000 negates to itself, which is exactly the required magnitude.
    assign w_abs      = bus.fixed_in[31] ? (~bus.fixed_in + 32'd1) : bus.fixed_in;

    assign w_exp      = c_EXP_TOP - {3'b000, r_count};
    assign w_frac     = r_mag[30:8];
    assign w_guard    = r_mag[7];
    assign w_sticky   = |r_mag[6:0];
    assign w_round_up = w_guard & (w_sticky | w_frac[0]);
    // Adding across the exponent/fraction boundary lets a fraction carry
    // bump the exponent for free; exp never exceeds 142 so no overflow.
    assign w_rounded  = {w_exp, w_frac} + {30'd0, w_round_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_mag       <= 32'd0;
            r_count     <= 5'd0;
            r_fp        <= 32'd0;
            r_inexact   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign  <= bus.fixed_in[31];
                        r_mag   <= w_abs;
                        r_count <= 5'd0;
                        if (bus.fixed_in == 32'd0) begin
                            r_fp        <= 32'd0;
                            r_inexact   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state     <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (r_mag[31]) begin
                        r_state <= ROUND;
                    end else begin
                        r_mag   <= r_mag << 1;
                        r_count <= r_count + 5'd1;
                    end
                end
                ROUND: begin
                    r_fp        <= {r_sign, w_rounded};
                    r_inexact   <= w_guard | w_sticky;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) & ~rst;
    assign bus.out_valid = r_out_valid;
    assign bus.fp_out    = r_fp;
    assign bus.inexact   = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fixed_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fixed_encoder
//  Description : Self-checking bench for fixed_encoder. Expected results come
//                from an integer model of Q16.16 -> IEEE single conversion.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fixed_encoder;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;
    int   rmode = 0;     // 0: out_ready high, 1: random, 2: held low

    typedef struct {
        logic [31:0] fp;
        logic        ix;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];

    fixed_encoder_if bus_if ();

    fixed_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value = mag * 2^-16. Locate the leading one, keep 24 significant bits,
    // round the rest to nearest-even on plain integers.
    function automatic void model(input logic [31:0] x, output logic [31:0] fp,
                                  output logic ix, output int lat);
        logic [31:0]     m;
        longint unsigned qv, rem, half;
        int              pos, sh, e;
        if (x == 32'd0) begin
            fp = 32'd0; ix = 1'b0; lat = 1;
            return;
        end
        m   = x[31] ? (32'd0 - x) : x;
        pos = 31;
        while (!m[pos]) pos--;
        lat = (31 - pos) + 3;
        e   = pos - 16 + 127;
        if (pos > 23) begin
            sh   = pos - 23;
            qv   = longint'(m) >> sh;
            rem  = longint'(m) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && qv[0])) qv++;
            ix = (rem != 0);
        end else begin
            qv = longint'(m) << (23 - pos);
            ix = 1'b0;
        end
        if (qv == (64'd1 << 24)) begin
            qv = qv >> 1;
            e++;
        end
        fp = {x[31], e[7:0], qv[22:0]};
    endfunction

    // out_ready driver, updated just after each rising edge
    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus_if.out_ready = 1'b1;
                1:       bus_if.out_ready = ($urandom_range(0, 2) != 0);
                default: bus_if.out_ready = 1'b0;
            endcase
        end
    end

    // Compare process: every falling edge, outputs against the expected queue
    logic first = 1'b1;
    logic hs_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            first   = 1'b1;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("idle_after_hs_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
                chk("idle_after_hs_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
            end
            hs_prev = 1'b0;
            if (q.size() == 0) begin
                chk("no_spurious_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
            end else if (bus_if.out_valid) begin
                chk("fp_out", bus_if.fp_out, q[0].fp);
                chk("inexact", {31'd0, bus_if.inexact}, {31'd0, q[0].ix});
                chk("in_ready_low_in_done", {31'd0, bus_if.in_ready}, 32'd0);
                if (first)
                    chk("latency", edge_cnt - q[0].acc + 1, q[0].lat);
                first = 1'b0;
                if (bus_if.out_ready) begin
                    void'(q.pop_front());
                    first   = 1'b1;
                    hs_prev = 1'b1;
                end
            end else if (edge_cnt - q[0].acc + 1 > q[0].lat + 2) begin
                chk("result_timeout", {31'd0, bus_if.out_valid}, 32'd1);
                void'(q.pop_front());
                first = 1'b1;
            end
        end
    end

    task automatic wait_in_ready();
        int n = 0;
        @(negedge clk);
        while (!bus_if.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.in_ready)
            chk("in_ready_timeout", {31'd0, bus_if.in_ready}, 32'd1);
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] efp,
                        input logic eix, input int elat, input bit track);
        exp_t e;
        wait_in_ready();
        bus_if.in_valid = 1'b1;
        bus_if.fixed_in = x;
        if (track) begin
            e.fp = efp; e.ix = eix; e.lat = elat; e.acc = edge_cnt + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        // Garbage on the operand while busy must be ignored.
        bus_if.fixed_in = $urandom;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] x);
        logic [31:0] fp;
        logic        ix;
        int          lat;
        model(x, fp, ix, lat);
        send(x, fp, ix, lat, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    logic [31:0] corners [6];
    initial begin
        logic [31:0] mfp;
        logic        mix;
        int          mlat;
        logic [31:0] r, x;

        corners[0] = 32'h0000_0000; corners[1] = 32'h8000_0000;
        corners[2] = 32'h7FFF_FFFF; corners[3] = 32'hFFFF_FFFF;
        corners[4] = 32'h01FF_FFFF; corners[5] = 32'h0000_0180;

        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.fixed_in = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("reset_fp_out", bus_if.fp_out, 32'd0);
        chk("reset_inexact", {31'd0, bus_if.inexact}, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", {31'd0, bus_if.in_ready}, 32'd1);

        // Pin the model on hand-derived values
        model(32'h0001_0000, mfp, mix, mlat);
        chk("model_one", mfp, 32'h3F80_0000);
        chk("model_one_lat", mlat, 18);
        model(32'h7FFF_FFFF, mfp, mix, mlat);
        chk("model_carry", mfp, 32'h4700_0000);
        chk("model_carry_ix", {31'd0, mix}, 32'd1);
        model(32'h0000_0001, mfp, mix, mlat);
        chk("model_lsb", mfp, 32'h3780_0000);

        // Directed vectors with literal expectations
        send(32'h0001_0000, 32'h3F80_0000, 1'b0, 18, 1'b1);
        send(32'hFFFF_0000, 32'hBF80_0000, 1'b0, 18, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 1,  1'b1);
        send(32'h8000_0000, 32'hC700_0000, 1'b0, 3,  1'b1);
        send(32'h7FFF_FFFF, 32'h4700_0000, 1'b1, 4,  1'b1);
        send(32'h0000_0001, 32'h3780_0000, 1'b0, 34, 1'b1);
        drain();

        // Back-pressure: result must hold while out_ready is low
        rmode = 2;
        send(32'h0001_8000, 32'h3FC0_0000, 1'b0, 18, 1'b1);
        begin
            int n = 0;
            while (!bus_if.out_valid && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
            chk("stall_fp_out", bus_if.fp_out, 32'h3FC0_0000);
            chk("stall_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        end
        rmode = 0;
        drain();

        // Reset in the middle of normalisation: nothing may come out
        send(32'h0001_0000, 32'd0, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready_rst", {31'd0, bus_if.in_ready}, 32'd0);
        chk("abort_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("abort_fp_out", bus_if.fp_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready_after", {31'd0, bus_if.in_ready}, 32'd1);
        repeat (40) @(negedge clk);

        // Randomised operands with random back-pressure
        rmode = 1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0:       x = r;
                1:       x = r >> $urandom_range(0, 31);
                2:       x = 32'd0 - (r >> $urandom_range(0, 31));
                3:       x = {8'h00, r[23:0]};
                default: x = corners[$urandom_range(0, 5)];
            endcase
            send_model(x);
        end
        rmode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
